instruction_memory_sync: RTL
============================

# instruction_memory_sync

Parametrised, synchronous successor to the combinational instruction store. Holds DEPTH = 2^DEPTH_LOG2 instruction words of width L in a register array. After reset it sweeps the array to a known image, then accepts program loads over a valid/ready write port and serves fetches with a registered one-cycle read. It sits between the program loader (testbench or boot logic) and the fetch stage of the i16 core.

## Interface
- L, 16: instruction word width in bits.
- DEPTH_LOG2, 8: implemented address bits; DEPTH = 2^DEPTH_LOG2 words.
- Clock  input  1  rising-edge clock, single clock domain.
- Reset  input  1  synchronous, active-high reset.
- LoadValid  input  1  load request.
- LoadReady  output  1  load accepted this cycle when high together with LoadValid.
- LoadAddress  input  L  word address to write.
- LoadData  input  L  instruction word to write.
- FetchRequest  input  1  fetch request.
- Address  input  L  word address to fetch.
- Instruction  output  L  registered fetch data.
- InstructionValid  output  1  one-cycle pulse marking Instruction as valid.
- AddressFault  output  1  qualifies InstructionValid: the fetch address was out of range.
- Busy  output  1  high while the init sweep runs.

## Operation
- State machine with two states:
  - INIT: entered on Reset. SweepPtr is written and incremented each cycle.
  - READY: entered when SweepPtr reaches DEPTH-1.
- INIT:
  - Writes the init image word for SweepPtr into mem[SweepPtr] each cycle.
  - Default image is all zeros.
  - Busy=1, LoadReady=0.
  - FetchRequest is ignored; no InstructionValid is generated.
- READY:
  - Busy=0, LoadReady=1.
  - LoadValid&LoadReady writes LoadData into mem[LoadAddress[DEPTH_LOG2-1:0]] at the clock edge.
  - The write happens only if LoadAddress[L-1:DEPTH_LOG2]==0. Otherwise the load is accepted and discarded.
- Fetch in READY:
  - FetchRequest=1 with Address in range: Instruction <= mem[Address], InstructionValid <= 1, AddressFault <= 0.
  - Address out of range (any bit at or above DEPTH_LOG2 set): Instruction <= 0, InstructionValid <= 1, AddressFault <= 1.
  - FetchRequest=0: InstructionValid <= 0, AddressFault <= 0, Instruction holds its last value.
- Load and fetch to the same address in the same cycle: the fetch returns the old contents (read-before-write). The new word is visible to fetches from the next cycle.
- When DEPTH_LOG2 == L, every address is in range.

## Timing
- Reset values: Instruction=0, InstructionValid=0, AddressFault=0, Busy=1, LoadReady=0, state=INIT, SweepPtr=0.
- INIT lasts exactly DEPTH cycles after Reset deasserts: Busy=1 on cycles 0..DEPTH-1 and drops in cycle DEPTH.
- Fetch latency is 1 cycle: a request sampled at edge N gives valid data after edge N, through edge N+1.
- Throughput is one fetch per cycle, back-to-back, with no stall.
- Loads complete in one cycle; LoadReady never drops in READY.
- Reset asserted at any point (mid-sweep, mid-load, mid-fetch):
  - The next edge returns all outputs to their reset values.
  - The sweep restarts from 0.
  - No pending InstructionValid survives.
  - Loaded contents are overwritten by the sweep.

## Configuration
- INSTRUCTION_MEMORY_PRESET_EN:
  - Defined: the INIT image holds the boot program and all other words are 0. The boot program is:
    - word 0 = 16'h6002
    - word 1 = 16'h6403
    - word 2 = 16'hE801
    - word 3 = 16'h4D7C
  - With L>16, the upper bits of the boot words are 0. Requires L>=16 and DEPTH_LOG2>=2; elaboration fails otherwise.
  - Undefined: the INIT image is all zeros.

## Test plan
- Reset with defaults: Busy=1 for exactly 256 cycles after Reset falls. Fetches issued during INIT give no InstructionValid. Afterwards, fetch of address 5 returns 0 with AddressFault=0.
- Load 16'hABCD to address 7, then fetch 7 the next cycle: Instruction=16'hABCD one cycle later with InstructionValid=1. Back-to-back fetches of addresses 7, 8, 7 return ABCD, 0, ABCD on consecutive cycles.
- Same-cycle load 16'h1234 and fetch to address 9 that previously held 16'h5555: the fetch returns 16'h5555. A fetch on the next cycle returns 16'h1234.
- Fetch address 16'h0100 (out of range at DEPTH_LOG2=8): Instruction=0, InstructionValid=1, AddressFault=1. A load to 16'h0100 is accepted and leaves address 0 unchanged.
- Reset asserted at sweep pointer 100, and again in READY after loading address 3: the sweep restarts with Busy=1 for 256 cycles, and address 3 then reads 0.
- With INSTRUCTION_MEMORY_PRESET_EN defined: fetches of addresses 0..3 after INIT return 6002, 6403, E801, 4D7C, and address 4 returns 0.

Source files
------------

// File: rtl/instruction_memory_sync_if.sv
// rtl/instruction_memory_sync_if.sv - load/fetch bus between loader, fetch stage and instruction_memory_sync
interface instruction_memory_sync_if #(
    parameter int L = 16
);
    logic         LoadValid;
    logic         LoadReady;
    logic [L-1:0] LoadAddress;
    logic [L-1:0] LoadData;
    logic         FetchRequest;
    logic [L-1:0] Address;
    logic [L-1:0] Instruction;
    logic         InstructionValid;
    logic         AddressFault;
    logic         Busy;

    modport master (
        output LoadValid, LoadAddress, LoadData, FetchRequest, Address,
        input  LoadReady, Instruction, InstructionValid, AddressFault, Busy
    );

    modport slave (
        input  LoadValid, LoadAddress, LoadData, FetchRequest, Address,
        output LoadReady, Instruction, InstructionValid, AddressFault, Busy
    );
endinterface

// File: rtl/instruction_memory_sync.sv
// rtl/instruction_memory_sync.sv - swept-init register-array instruction store with registered fetch
// Optional boot image: define INSTRUCTION_MEMORY_PRESET_EN.
module instruction_memory_sync #(
    parameter int L          = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    instruction_memory_sync_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] sweep_ptr;
    logic [L-1:0]          mem [DEPTH];
    logic [L-1:0]          init_data;
    logic [L-1:0]          instr_q;
    logic                  valid_q;
    logic                  fault_q;
    logic                  load_in_range;
    logic                  fetch_in_range;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [DEPTH_LOG2-1:0] fetch_addr;

    assign load_addr  = bus.LoadAddress[DEPTH_LOG2-1:0];
    assign fetch_addr = bus.Address[DEPTH_LOG2-1:0];

    // Any address bit above the implemented range marks the access as out of range.
    generate
        if (DEPTH_LOG2 < L) begin : g_partial
            assign load_in_range  = (bus.LoadAddress[L-1:DEPTH_LOG2] == '0);
            assign fetch_in_range = (bus.Address[L-1:DEPTH_LOG2] == '0);
        end else begin : g_full
            assign load_in_range  = 1'b1;
            assign fetch_in_range = 1'b1;
        end
    endgenerate

`ifdef INSTRUCTION_MEMORY_PRESET_EN
    generate
        if (L < 16 || DEPTH_LOG2 < 2) begin : g_bad_preset
            $error("boot image needs L >= 16 and DEPTH_LOG2 >= 2");
        end
    endgenerate

    always_comb begin
        init_data = '0;
        case (sweep_ptr)
            DEPTH_LOG2'(0): init_data = L'(16'h6002);
            DEPTH_LOG2'(1): init_data = L'(16'h6403);
            DEPTH_LOG2'(2): init_data = L'(16'hE801);
            DEPTH_LOG2'(3): init_data = L'(16'h4D7C);
            default:        init_data = '0;
        endcase
    end
`else
    assign init_data = '0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            if (state == ST_INIT) begin
                sweep_ptr <= sweep_ptr + DEPTH_LOG2'(1);
                if (sweep_ptr == '1) begin
                    state <= ST_READY;
                end
            end else if (bus.FetchRequest) begin
                valid_q <= 1'b1;
                if (fetch_in_range) begin
                    instr_q <= mem[fetch_addr];
                end else begin
                    instr_q <= '0;
                    fault_q <= 1'b1;
                end
            end
        end
    end

    // Same-edge load and fetch: the non-blocking write lands after the read, giving read-before-write.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state == ST_INIT) begin
                mem[sweep_ptr] <= init_data;
            end else if (bus.LoadValid && load_in_range) begin
                mem[load_addr] <= bus.LoadData;
            end
        end
    end

    assign bus.Instruction      = instr_q;
    assign bus.InstructionValid = valid_q;
    assign bus.AddressFault     = fault_q;
    assign bus.Busy             = (state == ST_INIT);
    assign bus.LoadReady        = (state == ST_READY);
endmodule
